// File: rtl/wtc_7seg_pkg.sv
// Shared 7-segment definitions: glyph encodings, segment bit positions and the
// pattern-to-digit decoder used by the receive-side monitor.
package wtc_7seg_pkg;

   localparam logic [6:0] SEG_GLYPH_0 = 7'h7E;
   localparam logic [6:0] SEG_GLYPH_1 = 7'h30;
   localparam logic [6:0] SEG_GLYPH_2 = 7'h6D;
   localparam logic [6:0] SEG_GLYPH_3 = 7'h79;
   localparam logic [6:0] SEG_GLYPH_4 = 7'h33;
   localparam logic [6:0] SEG_GLYPH_5 = 7'h5B;
   localparam logic [6:0] SEG_GLYPH_6 = 7'h5F;
   localparam logic [6:0] SEG_GLYPH_7 = 7'h70;
   localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
   localparam logic [6:0] SEG_GLYPH_9 = 7'h7B;
   localparam logic [6:0] SEG_GLYPH_A = 7'h77;
   localparam logic [6:0] SEG_GLYPH_B = 7'h1F;
   localparam logic [6:0] SEG_GLYPH_C = 7'h4E;
   localparam logic [6:0] SEG_GLYPH_D = 7'h3D;
   localparam logic [6:0] SEG_GLYPH_E = 7'h4F;
   localparam logic [6:0] SEG_GLYPH_F = 7'h47;

   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   typedef struct packed {
      logic       known;
      logic [3:0] digit;
   } seg_decode_t;

   function automatic seg_decode_t seg_decode(input logic [6:0] pattern);
      seg_decode_t res;
      res = {1'b0, 4'h0};
      case (pattern)
         SEG_GLYPH_0: res = {1'b1, 4'h0};
         SEG_GLYPH_1: res = {1'b1, 4'h1};
         SEG_GLYPH_2: res = {1'b1, 4'h2};
         SEG_GLYPH_3: res = {1'b1, 4'h3};
         SEG_GLYPH_4: res = {1'b1, 4'h4};
         SEG_GLYPH_5: res = {1'b1, 4'h5};
         SEG_GLYPH_6: res = {1'b1, 4'h6};
         SEG_GLYPH_7: res = {1'b1, 4'h7};
         SEG_GLYPH_8: res = {1'b1, 4'h8};
         SEG_GLYPH_9: res = {1'b1, 4'h9};
         SEG_GLYPH_A: res = {1'b1, 4'hA};
         SEG_GLYPH_B: res = {1'b1, 4'hB};
         SEG_GLYPH_C: res = {1'b1, 4'hC};
         SEG_GLYPH_D: res = {1'b1, 4'hD};
         SEG_GLYPH_E: res = {1'b1, 4'hE};
         SEG_GLYPH_F: res = {1'b1, 4'hF};
         default:     res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/wtc_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-zero.
module wtc_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1_r;

   // Two-stage capture of the asynchronous inputs
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         s1_r <= '0;
         q    <= '0;
      end else begin
         s1_r <= d;
         q    <= s1_r;
      end
   end

endmodule

// File: rtl/wtc_7seg_decode.sv
// Receive-side 7-segment monitor: synchronizes and debounces the segment lines,
// decodes accepted patterns to hex digits and measures the segment-A toggle period.
module wtc_7seg_decode
   import wtc_7seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int PERIOD_W      = 32,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Segment_A,
   input  logic                i_Segment_B,
   input  logic                i_Segment_C,
   input  logic                i_Segment_D,
   input  logic                i_Segment_E,
   input  logic                i_Segment_F,
   input  logic                i_Segment_G,
   output logic                o_Valid,
   output logic [6:0]          o_Pattern,
   output logic [3:0]          o_Binary_Num,
   output logic                o_Known,
   output logic                o_Blank,
   output logic [PERIOD_W-1:0] o_Toggle_Period,
   output logic                o_Period_Valid
);

   localparam int                   CNT_W     = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [PERIOD_W-1:0]  PCNT_MAX  = '1;
   localparam logic [PERIOD_W-1:0]  PCNT_ONE  = PERIOD_W'(1);

   logic [6:0]          seg_raw_s;
   logic [6:0]          seg_norm_s;
   logic [6:0]          seg_sync_s;
   logic [6:0]          cand_r;
   logic [CNT_W-1:0]    cnt_r;
   seg_decode_t         dec_s;
   logic                last_a_r;
   logic                seen_r;
   logic [PERIOD_W-1:0] pcnt_r;
   logic [PERIOD_W-1:0] pnext_s;

   // Gather segment lines into A-at-bit-6 order
   always_comb begin
      seg_raw_s        = 7'h00;
      seg_raw_s[SEG_A] = i_Segment_A;
      seg_raw_s[SEG_B] = i_Segment_B;
      seg_raw_s[SEG_C] = i_Segment_C;
      seg_raw_s[SEG_D] = i_Segment_D;
      seg_raw_s[SEG_E] = i_Segment_E;
      seg_raw_s[SEG_F] = i_Segment_F;
      seg_raw_s[SEG_G] = i_Segment_G;
   end

   // Normalising before the synchronizer makes its reset value mean "segment off"
   assign seg_norm_s = ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;

   wtc_sync2 #(.WIDTH(7)) u_sync (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .d       (seg_norm_s),
      .q       (seg_sync_s)
   );

   // Glyph lookup for the current candidate
   always_comb begin
      dec_s = seg_decode(cand_r);
   end

   // Stability filter: accept a candidate once it has held for STABLE_CYCLES and differs from the last one
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cand_r       <= 7'h00;
         cnt_r        <= '0;
         o_Valid      <= 1'b0;
         o_Pattern    <= 7'h00;
         o_Binary_Num <= 4'h0;
         o_Known      <= 1'b0;
         o_Blank      <= 1'b0;
      end else begin
         o_Valid <= 1'b0;
         if (seg_sync_s != cand_r) begin
            cand_r <= seg_sync_s;
            cnt_r  <= '0;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else if (cand_r != o_Pattern) begin
            o_Valid      <= 1'b1;
            o_Pattern    <= cand_r;
            o_Binary_Num <= dec_s.digit;
            o_Known      <= dec_s.known;
            o_Blank      <= (cand_r == 7'h00);
         end
      end
   end

   // Saturating period + 1 reported on a toggle
   assign pnext_s = (pcnt_r == PCNT_MAX) ? pcnt_r : (pcnt_r + PCNT_ONE);

   // Segment-A period meter on the raw synchronized line; the first toggle only arms it
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         last_a_r        <= 1'b0;
         seen_r          <= 1'b0;
         pcnt_r          <= '0;
         o_Toggle_Period <= '0;
         o_Period_Valid  <= 1'b0;
      end else begin
         o_Period_Valid <= 1'b0;
         if (seg_sync_s[SEG_A] != last_a_r) begin
            last_a_r <= seg_sync_s[SEG_A];
            seen_r   <= 1'b1;
            pcnt_r   <= '0;
            if (seen_r) begin
               o_Toggle_Period <= pnext_s;
               o_Period_Valid  <= 1'b1;
            end
         end else if (pcnt_r != PCNT_MAX) begin
            pcnt_r <= pcnt_r + PCNT_ONE;
         end
      end
   end

endmodule
